// File: rtl/bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bus_ctrl_pkg
// Shared definitions for the register-bus transfer controller:
//   - default register count and select width
//   - requester ids (bit positions in the two-bit request/grant vectors)
//   - transfer FSM state encodings
// -----------------------------------------------------------------------------
package bus_ctrl_pkg;

    localparam int DEF_NUM_REGS  = 4;
    localparam int DEF_SEL_WIDTH = 2;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        DRIVE = ST_DRIVE,
        LOAD  = ST_LOAD,
        DONE  = ST_DONE
    } xfer_state_e;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. Under contention the side named by the
// pointer wins; a lone requester always wins. The pointer toggles only when
// the owner pulses i_advance.
//
// Ports:
//   i_clk      rising-edge clock
//   i_reset    synchronous active-high reset (pointer -> requester A)
//   i_req      request vector, bit REQ_A / REQ_B
//   i_advance  toggle the pointer at the next edge
//   o_grant    one-hot grant (all zero when nobody requests)
//   o_ptr      current pointer (0 = A, 1 = B)
// -----------------------------------------------------------------------------
module rr_arb2
    import bus_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant,
    output logic       o_ptr
);

    logic r_ptr;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = (r_ptr == REQ_B) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= REQ_A;
        end else if (i_advance) begin
            r_ptr <= ~r_ptr;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/bus_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctrl
// Sequences register-to-register moves over the shared tri-state data bus.
// Two requesters post {src, dst}; a round-robin arbiter picks one, and the
// FSM drives the active-low output-enable of the source and then the
// load-enable of the destination so exactly one register drives and one
// register loads. All outputs come straight from flops.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no strobes; grant a request or reject it with an Err pulse
// DRIVE | OE_n[src] low, bus settle cycle
// LOAD  | OE_n[src] low, EN_n[dst] low; dst captures at the next edge
// DONE  | strobes released, Done pulse to the owner
//
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_req_a/b                   level requests, held until Done/Err
//   i_src_a/b, i_dst_a/b        register indices, stable while requesting
//   o_done_a/b                  one-cycle transfer-complete pulse
//   o_err_a/b                   one-cycle reject pulse (src==dst / range)
//   o_busy                      high whenever the FSM is not in IDLE
//   o_oe_n, o_en_n              per-register output / load enables, low active
// -----------------------------------------------------------------------------
module bus_xfer_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int NumRegs  = DEF_NUM_REGS,
    parameter int SelWidth = DEF_SEL_WIDTH
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req_a,
    input  logic [SelWidth-1:0] i_src_a,
    input  logic [SelWidth-1:0] i_dst_a,
    input  logic                i_req_b,
    input  logic [SelWidth-1:0] i_src_b,
    input  logic [SelWidth-1:0] i_dst_b,
    output logic                o_done_a,
    output logic                o_done_b,
    output logic                o_err_a,
    output logic                o_err_b,
    output logic                o_busy,
    output logic [NumRegs-1:0]  o_oe_n,
    output logic [NumRegs-1:0]  o_en_n
);

    function automatic logic [NumRegs-1:0] sel_to_strobe_n(input logic [SelWidth-1:0] sel);
        logic [NumRegs-1:0] v;
        v = '1;
        for (int i = 0; i < NumRegs; i++) begin
            if (sel == SelWidth'(i)) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    logic [1:0]          r_state;
    logic                r_owner;
    logic [SelWidth-1:0] r_dst;
    logic [1:0]          r_done;
    logic [1:0]          r_err;
    logic                r_busy;
    logic [NumRegs-1:0]  r_oe_n;
    logic [NumRegs-1:0]  r_en_n;

    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    logic                w_unused_ptr;
    logic                w_owner;
    logic [SelWidth-1:0] w_src;
    logic [SelWidth-1:0] w_dst;
    logic                w_valid;
    logic                w_fire;
    logic                w_advance;

    assign w_req[REQ_A] = i_req_a;
    assign w_req[REQ_B] = i_req_b;

    // Pointer is kept inside the arbiter; it is not needed here beyond grant.
    rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_req     (w_req),
        .i_advance (w_advance),
        .o_grant   (w_grant),
        .o_ptr     (w_unused_ptr)
    );

    assign w_owner = w_grant[REQ_B];
    assign w_src   = w_owner ? i_src_b : i_src_a;
    assign w_dst   = w_owner ? i_dst_b : i_dst_a;
    assign w_valid = (w_src != w_dst) && (int'(w_src) < NumRegs) && (int'(w_dst) < NumRegs);
    assign w_fire  = (r_state == ST_IDLE) && (|w_req);

    // Contention hands priority to the other side; a rejected request also
    // yields priority so a requester stuck on a bad index cannot hog the bus.
    assign w_advance = w_fire && ((&w_req) || !w_valid);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_owner <= REQ_A;
            r_dst   <= '0;
            r_done  <= 2'b00;
            r_err   <= 2'b00;
            r_busy  <= 1'b0;
            r_oe_n  <= '1;
            r_en_n  <= '1;
        end else begin
            r_done <= 2'b00;
            r_err  <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        if (w_valid) begin
                            r_owner <= w_owner;
                            r_dst   <= w_dst;
                            r_oe_n  <= sel_to_strobe_n(w_src);
                            r_busy  <= 1'b1;
                            r_state <= ST_DRIVE;
                        end else begin
                            r_err[w_owner] <= 1'b1;
                        end
                    end
                end
                ST_DRIVE: begin
                    r_en_n  <= sel_to_strobe_n(r_dst);
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_oe_n          <= '1;
                    r_en_n          <= '1;
                    r_done[r_owner] <= 1'b1;
                    r_state         <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_oe_n  <= '1;
                    r_en_n  <= '1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_done_a = r_done[REQ_A];
    assign o_done_b = r_done[REQ_B];
    assign o_err_a  = r_err[REQ_A];
    assign o_err_b  = r_err[REQ_B];
    assign o_busy   = r_busy;
    assign o_oe_n   = r_oe_n;
    assign o_en_n   = r_en_n;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_xfer_ctrl
// Bench for bus_xfer_ctrl with a 4 x 8-bit register bank hanging off the
// strobes. A transaction-level reference predicts, from each grant, the
// outputs of the following cycles (strobes, pulses, busy) and the value the
// destination must hold once the move completes.
// -----------------------------------------------------------------------------
module tb_bus_xfer_ctrl;

    localparam int NREG = 4;
    localparam int RING = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b;
    logic [1:0] src_a, dst_a, src_b, dst_b;
    logic       done_a, done_b, err_a, err_b, busy;
    logic [3:0] oe_n, en_n;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.NumRegs(NREG), .SelWidth(2)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_req_a  (req_a),
        .i_src_a  (src_a),
        .i_dst_a  (dst_a),
        .i_req_b  (req_b),
        .i_src_b  (src_b),
        .i_dst_b  (dst_b),
        .o_done_a (done_a),
        .o_done_b (done_b),
        .o_err_a  (err_a),
        .o_err_b  (err_b),
        .o_busy   (busy),
        .o_oe_n   (oe_n),
        .o_en_n   (en_n)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- register bank on the bus ----------------
    logic [7:0] preset [NREG];
    logic [7:0] bank   [NREG];
    logic [7:0] bus_val;

    always_comb begin
        bus_val = 8'h00;
        for (int j = 0; j < NREG; j++) begin
            if (!oe_n[j]) bus_val = bank[j];
        end
    end

    always @(posedge clk) begin
        for (int j = 0; j < NREG; j++) begin
            if (rst) bank[j] <= preset[j];
            else if (!en_n[j]) bank[j] <= bus_val;
        end
    end

    // ---------------- reference: per-cycle expectations ----------------
    logic [3:0] exp_oe   [RING];
    logic [3:0] exp_en   [RING];
    logic [1:0] exp_done [RING];
    logic [1:0] exp_err  [RING];
    logic       exp_busy [RING];
    logic       exp_dchk [RING];
    int         exp_didx [RING];
    logic [7:0] exp_dval [RING];

    task automatic clear_slot(input int k);
        exp_oe[k]   = 4'hF;
        exp_en[k]   = 4'hF;
        exp_done[k] = 2'b00;
        exp_err[k]  = 2'b00;
        exp_busy[k] = 1'b0;
        exp_dchk[k] = 1'b0;
        exp_didx[k] = 0;
        exp_dval[k] = 8'h00;
    endtask

    initial begin
        int ptr;
        int free_at;
        for (int k = 0; k < RING; k++) clear_slot(k);
        ptr = 0;
        free_at = 0;
        forever begin
            @(posedge clk);
            clear_slot(cyc % RING);
            if (rst) begin
                for (int k = 0; k < RING; k++) clear_slot(k);
                ptr = 0;
                free_at = cyc + 1;
            end else if (cyc >= free_at && (req_a || req_b)) begin
                int   owner;
                logic both;
                int   s, d;
                logic ok;
                both  = req_a && req_b;
                owner = both ? ptr : (req_b ? 1 : 0);
                s     = (owner == 1) ? int'(src_b) : int'(src_a);
                d     = (owner == 1) ? int'(dst_b) : int'(dst_a);
                ok    = (s != d) && (s < NREG) && (d < NREG);
                if (both || !ok) ptr = 1 - ptr;
                if (ok) begin
                    for (int k = 1; k <= 3; k++) exp_busy[(cyc + k) % RING] = 1'b1;
                    exp_oe[(cyc + 1) % RING] = ~(4'b0001 << s);
                    exp_oe[(cyc + 2) % RING] = ~(4'b0001 << s);
                    exp_en[(cyc + 2) % RING] = ~(4'b0001 << d);
                    exp_done[(cyc + 3) % RING][owner] = 1'b1;
                    exp_dchk[(cyc + 3) % RING] = 1'b1;
                    exp_didx[(cyc + 3) % RING] = d;
                    exp_dval[(cyc + 3) % RING] = bank[s];
                    free_at = cyc + 4;
                end else begin
                    exp_err[(cyc + 1) % RING][owner] = 1'b1;
                    free_at = cyc + 1;
                end
            end
            cyc = cyc + 1;
        end
    end

    // ---------------- per-cycle checker and pulse counters ----------------
    int n_done_seen = 0;
    int n_err_seen  = 0;
    int n_valid_issued = 0;
    int n_inv_issued   = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                int k;
                k = cyc % RING;
                check_val("oe_n",   32'(oe_n),   32'(exp_oe[k]));
                check_val("en_n",   32'(en_n),   32'(exp_en[k]));
                check_val("done",   32'({done_b, done_a}), 32'(exp_done[k]));
                check_val("err",    32'({err_b, err_a}),   32'(exp_err[k]));
                check_val("busy",   32'(busy),   32'(exp_busy[k]));
                if (exp_dchk[k]) check_val("dst_data", 32'(bank[exp_didx[k]]), 32'(exp_dval[k]));
                check_val("oe_single_low", 32'($countones(~oe_n) <= 1), 32'd1);
                check_val("en_single_low", 32'($countones(~en_n) <= 1), 32'd1);
                if (en_n != 4'hF) begin
                    check_val("en_needs_other_oe",
                              32'((oe_n != 4'hF) && ((~oe_n & ~en_n) == 4'h0)), 32'd1);
                end
                n_done_seen += int'(done_a) + int'(done_b);
                n_err_seen  += int'(err_a) + int'(err_b);
            end
        end
    end

    // ---------------- requester driver ----------------
    // Called on a falling edge; returns on the falling edge where Done/Err is
    // seen, with Req already dropped so the next rising edge sees it low.
    task automatic do_req(input int side, input logic [1:0] s, input logic [1:0] d,
                          output int kind, output int at_cyc);
        int exp_kind;
        exp_kind = (s != d) ? 1 : 2;
        if (exp_kind == 1) n_valid_issued++;
        else n_inv_issued++;
        if (side == 0) begin src_a = s; dst_a = d; req_a = 1'b1; end
        else           begin src_b = s; dst_b = d; req_b = 1'b1; end
        kind = 0;
        for (int n = 0; n < 60 && kind == 0; n++) begin
            @(negedge clk);
            if (side == 0) begin
                if (done_a) kind = 1;
                else if (err_a) kind = 2;
            end else begin
                if (done_b) kind = 1;
                else if (err_b) kind = 2;
            end
        end
        at_cyc = cyc;
        if (side == 0) req_a = 1'b0;
        else req_b = 1'b0;
        check_val((side == 0) ? "outcome_a" : "outcome_b", 32'(kind), 32'(exp_kind));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ka, kb, ta, tb, t0;
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        src_a = 2'd0; dst_a = 2'd0; src_b = 2'd0; dst_b = 2'd0;
        for (int i = 0; i < NREG; i++) preset[i] = 8'($urandom);
        preset[1] = 8'h5A;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_oe_n", 32'(oe_n), 32'hF);
        check_val("rst_en_n", 32'(en_n), 32'hF);
        check_val("rst_busy", 32'(busy), 32'd0);

        // single move R1 -> R3
        t0 = cyc;
        do_req(0, 2'd1, 2'd3, ka, ta);
        check_val("t1_latency", 32'(ta - t0), 32'd3);
        check_val("t1_r3", 32'(bank[3]), 32'h5A);
        @(negedge clk);

        // simultaneous pair: A first, then B four cycles later
        fork
            do_req(0, 2'd0, 2'd2, ka, ta);
            do_req(1, 2'd3, 2'd1, kb, tb);
        join
        check_val("pair1_b_after_a", 32'(tb - ta), 32'd4);
        @(negedge clk);

        // next simultaneous pair: B first
        fork
            do_req(0, 2'd2, 2'd0, ka, ta);
            do_req(1, 2'd1, 2'd3, kb, tb);
        join
        check_val("pair2_a_after_b", 32'(ta - tb), 32'd4);
        @(negedge clk);

        // rejected request from B; pointer flips to B
        t0 = cyc;
        do_req(1, 2'd2, 2'd2, kb, tb);
        check_val("err_latency", 32'(tb - t0), 32'd1);
        check_val("err_busy", 32'(busy), 32'd0);
        check_val("err_oe_n", 32'(oe_n), 32'hF);
        @(negedge clk);
        fork
            do_req(0, 2'd1, 2'd0, ka, ta);
            do_req(1, 2'd2, 2'd3, kb, tb);
        join
        check_val("pair3_a_after_b", 32'(ta - tb), 32'd4);
        @(negedge clk);

        // reset during LOAD aborts the move without a Done
        src_a = 2'd0; dst_a = 2'd1; req_a = 1'b1;
        begin
            bit seen_load;
            seen_load = 1'b0;
            for (int n = 0; n < 10 && !seen_load; n++) begin
                @(negedge clk);
                if (en_n != 4'hF) seen_load = 1'b1;
            end
            check_val("abort_reached_load", 32'(seen_load), 32'd1);
        end
        rst = 1'b1;
        req_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_oe_n", 32'(oe_n), 32'hF);
        check_val("abort_en_n", 32'(en_n), 32'hF);
        check_val("abort_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        do_req(0, 2'd2, 2'd3, ka, ta);
        @(negedge clk);

        // random soak, 500 requests per port
        fork
            begin
                int k, t;
                for (int i = 0; i < 500; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_req(0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), k, t);
                end
            end
            begin
                int k, t;
                for (int i = 0; i < 500; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_req(1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), k, t);
                end
            end
        join

        repeat (6) @(negedge clk);
        check_val("total_done", 32'(n_done_seen), 32'(n_valid_issued));
        check_val("total_err",  32'(n_err_seen),  32'(n_inv_issued));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
